// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, partial-product vector type and stage control payload for mul_csa_pipe
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;
    localparam int NUM_PP = 32;

    typedef logic [NUM_PP-1:0][MUL_W-1:0] pp_vec_t;

    typedef struct packed {
        logic is_signed;
        logic hi;
    } op_ctrl_t;

    // Widen one partial product to the product width before it is shifted into place.
    function automatic logic [PROD_W-1:0] ext_row(input logic [MUL_W-1:0] pp, input logic is_signed);
        return is_signed ? {{MUL_W{pp[MUL_W-1]}}, pp} : {{MUL_W{1'b0}}, pp};
    endfunction

endpackage

// File: rtl/csa32.sv
// rtl/csa32.sv - generic-width 3:2 carry-save adder row; carry is pre-shifted and truncated to W bits
module csa32 #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/mul_csa_pipe.sv
// rtl/mul_csa_pipe.sv - 3-stage CSA reduction + CPA of Booth partial products with valid/ready, stall and flush
// Optional counters perf_ops/perf_stall are built when MUL_CSA_PERF_CNT_EN is defined.
module mul_csa_pipe
    import mul_pkg::*;
#(
    parameter int ID_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic              in_hi,
    input  logic [ID_W-1:0]   in_tag,
    input  pp_vec_t           in_pp,
    input  logic [NUM_PP-1:0] in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic [MUL_W-1:0]  out_result,
    output logic [ID_W-1:0]   out_tag
`ifdef MUL_CSA_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);

    typedef struct packed {
        op_ctrl_t        ctrl;
        logic [ID_W-1:0] tag;
    } payload_t;

    logic              s1_valid_q, s1_valid_d;
    payload_t          s1_pl_q, s1_pl_d;
    pp_vec_t           s1_pp_q, s1_pp_d;
    logic [NUM_PP-1:0] s1_sign_q, s1_sign_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_hi_q, s2_hi_d;
    logic [ID_W-1:0]   s2_tag_q, s2_tag_d;
    logic [PROD_W-1:0] s2_rows_q [6];
    logic [PROD_W-1:0] s2_rows_d [6];

    logic              s3_valid_q, s3_valid_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [MUL_W-1:0]  result_q, result_d;
    logic [ID_W-1:0]   tag_q, tag_d;

    logic s1_load, s2_load, s3_load, s3_fire;

    // S1 reduction: 33 -> 22 -> 15 -> 10 -> 7 -> 6 rows
    logic [PROD_W-1:0] r0 [33];
    logic [PROD_W-1:0] r1 [22];
    logic [PROD_W-1:0] r2 [15];
    logic [PROD_W-1:0] r3 [10];
    logic [PROD_W-1:0] r4 [7];
    logic [PROD_W-1:0] r5 [6];

    genvar g;
    for (g = 0; g < NUM_PP; g++) begin : g_rows
        assign r0[g] = ext_row(s1_pp_q[g], s1_pl_q.ctrl.is_signed) << g;
    end
    assign r0[NUM_PP] = s1_pl_q.ctrl.is_signed ? {{(PROD_W-NUM_PP){1'b0}}, s1_sign_q} : '0;

    for (g = 0; g < 11; g++) begin : g_l1
        csa32 #(.W(PROD_W)) u_csa (.a(r0[3*g]), .b(r0[3*g+1]), .c(r0[3*g+2]),
                                   .sum(r1[2*g]), .carry(r1[2*g+1]));
    end
    for (g = 0; g < 7; g++) begin : g_l2
        csa32 #(.W(PROD_W)) u_csa (.a(r1[3*g]), .b(r1[3*g+1]), .c(r1[3*g+2]),
                                   .sum(r2[2*g]), .carry(r2[2*g+1]));
    end
    assign r2[14] = r1[21];
    for (g = 0; g < 5; g++) begin : g_l3
        csa32 #(.W(PROD_W)) u_csa (.a(r2[3*g]), .b(r2[3*g+1]), .c(r2[3*g+2]),
                                   .sum(r3[2*g]), .carry(r3[2*g+1]));
    end
    for (g = 0; g < 3; g++) begin : g_l4
        csa32 #(.W(PROD_W)) u_csa (.a(r3[3*g]), .b(r3[3*g+1]), .c(r3[3*g+2]),
                                   .sum(r4[2*g]), .carry(r4[2*g+1]));
    end
    assign r4[6] = r3[9];
    csa32 #(.W(PROD_W)) u_l5 (.a(r4[0]), .b(r4[1]), .c(r4[2]), .sum(r5[0]), .carry(r5[1]));
    for (g = 0; g < 4; g++) begin : g_l5_pass
        assign r5[2+g] = r4[3+g];
    end

    // S2 reduction: 6 -> 4 -> 3 -> 2 rows, then the carry-propagate add
    logic [PROD_W-1:0] t1 [4];
    logic [PROD_W-1:0] t2 [3];
    logic [PROD_W-1:0] t3 [2];
    logic [PROD_W-1:0] cpa_sum;

    csa32 #(.W(PROD_W)) u_sa0 (.a(s2_rows_q[0]), .b(s2_rows_q[1]), .c(s2_rows_q[2]),
                               .sum(t1[0]), .carry(t1[1]));
    csa32 #(.W(PROD_W)) u_sa1 (.a(s2_rows_q[3]), .b(s2_rows_q[4]), .c(s2_rows_q[5]),
                               .sum(t1[2]), .carry(t1[3]));
    csa32 #(.W(PROD_W)) u_sb0 (.a(t1[0]), .b(t1[1]), .c(t1[2]), .sum(t2[0]), .carry(t2[1]));
    assign t2[2] = t1[3];
    csa32 #(.W(PROD_W)) u_sc0 (.a(t2[0]), .b(t2[1]), .c(t2[2]), .sum(t3[0]), .carry(t3[1]));
    assign cpa_sum = t3[0] + t3[1];

    always_comb begin
        s3_fire  = s3_valid_q && out_ready;
        s3_load  = !flush && s2_valid_q && (!s3_valid_q || s3_fire);
        s2_load  = !flush && s1_valid_q && (!s2_valid_q || s3_load);
        in_ready = !flush && (!s1_valid_q || s2_load);
        s1_load  = in_valid && in_ready;

        s1_valid_d = !flush && (s1_load || (s1_valid_q && !s2_load));
        s2_valid_d = !flush && (s2_load || (s2_valid_q && !s3_load));
        s3_valid_d = !flush && (s3_load || (s3_valid_q && !s3_fire));

        s1_pl_d   = s1_pl_q;
        s1_pp_d   = s1_pp_q;
        s1_sign_d = s1_sign_q;
        if (s1_load) begin
            s1_pl_d.ctrl.is_signed = in_signed;
            s1_pl_d.ctrl.hi        = in_hi;
            s1_pl_d.tag            = in_tag;
            s1_pp_d                = in_pp;
            s1_sign_d              = in_sign;
        end

        s2_hi_d  = s2_load ? s1_pl_q.ctrl.hi : s2_hi_q;
        s2_tag_d = s2_load ? s1_pl_q.tag : s2_tag_q;
        for (int k = 0; k < 6; k++) begin
            s2_rows_d[k] = s2_load ? r5[k] : s2_rows_q[k];
        end

        prod_d   = prod_q;
        result_d = result_q;
        tag_d    = tag_q;
        if (s3_load) begin
            prod_d   = cpa_sum;
            result_d = s2_hi_q ? cpa_sum[PROD_W-1:MUL_W] : cpa_sum[MUL_W-1:0];
            tag_d    = s2_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            prod_q     <= '0;
            result_q   <= '0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            prod_q     <= prod_d;
            result_q   <= result_d;
            tag_q      <= tag_d;
        end
    end

    // Wide datapath registers are qualified by their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        s1_pl_q   <= s1_pl_d;
        s1_pp_q   <= s1_pp_d;
        s1_sign_q <= s1_sign_d;
        s2_hi_q   <= s2_hi_d;
        s2_tag_q  <= s2_tag_d;
        s2_rows_q <= s2_rows_d;
    end

    assign out_valid  = s3_valid_q;
    assign out_prod   = prod_q;
    assign out_result = result_q;
    assign out_tag    = tag_q;

`ifdef MUL_CSA_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q + {31'b0, s3_fire};
        perf_stall_d = perf_stall_q + {31'b0, s3_valid_q && !out_ready};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_csa_pipe.sv
// tb/tb_mul_csa_pipe.sv - self-checking bench for mul_csa_pipe: queue model, directed cases, random traffic
module tb_mul_csa_pipe;
    import mul_pkg::*;

    localparam int ID_W = 5;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, in_signed, in_hi;
    logic [ID_W-1:0]   in_tag;
    pp_vec_t           in_pp;
    logic [31:0]       in_sign;
    logic              out_valid, out_ready;
    logic [63:0]       out_prod;
    logic [31:0]       out_result;
    logic [ID_W-1:0]   out_tag;
`ifdef MUL_CSA_PERF_CNT_EN
    logic [31:0]       perf_ops, perf_stall;
    logic [31:0]       m_ops, m_stall;
`endif

    mul_csa_pipe #(.ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed), .in_hi(in_hi),
        .in_tag(in_tag), .in_pp(in_pp), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
        .out_result(out_result), .out_tag(out_tag)
`ifdef MUL_CSA_PERF_CNT_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [63:0]     prod;
        logic [31:0]     result;
        logic [ID_W-1:0] tag;
        int              age;
    } exp_t;
    exp_t q[$];
    exp_t e_new;
    logic exp_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference arithmetic: sum of widened pp_i << i plus sign bits (signed mode only), mod 2^64.
    function automatic logic [63:0] ref_prod(input pp_vec_t pp, input logic [31:0] sg, input logic sgn);
        logic [63:0] acc = 64'd0;
        for (int i = 0; i < 32; i++) begin
            acc += (sgn ? 64'($signed(pp[i])) : 64'(pp[i])) << i;
            if (sgn) acc += 64'(sg[i]) << i;
        end
        return acc;
    endfunction

    // Radix-2 operand expansion: the top row is negated in signed mode via ~x plus a sign bit.
    task automatic gen_ops(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                           output pp_vec_t pp, output logic [31:0] sg);
        pp = '0;
        sg = '0;
        for (int i = 0; i < 32; i++) pp[i] = y[i] ? x : 32'd0;
        if (sgn && y[31]) begin
            pp[31] = ~x;
            sg[31] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
`ifdef MUL_CSA_PERF_CNT_EN
            m_ops = 0;
            m_stall = 0;
`endif
        end else begin
            for (int i = 0; i < q.size(); i++) q[i].age++;
            chk("in_ready", 64'(in_ready), 64'(!flush && (q.size() < 3 || out_ready)));
            exp_ov = (q.size() > 0) && (q[0].age >= 3);
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            if (out_valid && exp_ov) begin
                chk("out_prod", out_prod, q[0].prod);
                chk("out_result", 64'(out_result), 64'(q[0].result));
                chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            end
`ifdef MUL_CSA_PERF_CNT_EN
            chk("perf_ops", 64'(perf_ops), 64'(m_ops));
            chk("perf_stall", 64'(perf_stall), 64'(m_stall));
            if (exp_ov && out_ready) m_ops++;
            if (exp_ov && !out_ready) m_stall++;
`endif
            if (exp_ov && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && in_ready) begin
                e_new.prod   = ref_prod(in_pp, in_sign, in_signed);
                e_new.result = in_hi ? e_new.prod[63:32] : e_new.prod[31:0];
                e_new.tag    = in_tag;
                e_new.age    = 0;
                q.push_back(e_new);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                            input logic hi, input logic [ID_W-1:0] tag);
        pp_vec_t     pp;
        logic [31:0] sg;
        gen_ops(x, y, sgn, pp, sg);
        in_pp     = pp;
        in_sign   = sg;
        in_signed = sgn;
        in_hi     = hi;
        in_tag    = tag;
        in_valid  = 1'b1;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sgn, input logic hi,
                          input logic [ID_W-1:0] tag, output int lat, output logic [63:0] prod,
                          output logic [31:0] res);
        logic acc = 1'b0;
        lat  = -1;
        prod = '0;
        res  = '0;
        tick();
        out_ready = 1'b1;
        drive_op(x, y, sgn, hi, tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        if (!acc) begin
            chk("accept_timeout", 64'd0, 64'd1);
            tick();
            in_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                lat  = k;
                prod = out_prod;
                res  = out_result;
                break;
            end
        end
    endtask

    int          lat, sent, got, cnt;
    logic [63:0] p;
    logic [31:0] r;
    logic [ID_W-1:0] tags [4];
    logic [63:0] prods [4];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_hi = 1'b0;
        in_tag = '0; in_pp = '0; in_sign = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_prod", out_prod, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);

        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 5'd7, lat, p, r);
        chk("neg3x5_latency", 64'(lat), 64'd3);
        chk("neg3x5_prod", p, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("neg3x5_lo", 64'(r), 64'h0000_0000_FFFF_FFF1);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 5'd8, lat, p, r);
        chk("neg3x5_hi", 64'(r), 64'h0000_0000_FFFF_FFFF);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd9, lat, p, r);
        chk("umax_prod", p, 64'hFFFF_FFFE_0000_0001);
        chk("umax_hi", 64'(r), 64'h0000_0000_FFFF_FFFE);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 5'd10, lat, p, r);
        chk("smin_hi", 64'(r), 64'h0000_0000_4000_0000);
        chk("smin_lo_word", 64'(p[31:0]), 64'd0);

        // Backpressure: four back-to-back ops, consumer stalled for five cycles.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            tick();
            out_ready = (cyc >= 5);
            if (sent < 4) drive_op(32'(1000 * (sent + 1)), 32'(sent + 3), 1'b0, 1'b0, ID_W'(sent + 1));
            else in_valid = 1'b0;
            @(negedge clk);
            if (cyc == 4) begin
                chk("bp_accepts", 64'(sent), 64'd3);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_tag", 64'(out_tag), 64'd1);
                chk("bp_hold_prod", out_prod, 64'd3000);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                tags[got]  = out_tag;
                prods[got] = out_prod;
                got++;
            end
        end
        chk("bp_drained", 64'(got), 64'd4);
        for (int i = 0; i < 4 && i < got; i++) begin
            chk("bp_order_tag", 64'(tags[i]), 64'(i + 1));
            chk("bp_order_prod", prods[i], 64'(1000 * (i + 1) * (i + 3)));
        end

        // Flush with two ops in flight.
        tick(); in_valid = 1'b0; out_ready = 1'b1;
        tick(); drive_op(32'd7, 32'd9, 1'b0, 1'b0, 5'd11);
        @(negedge clk); chk("fl_accept0", 64'(in_ready), 64'd1);
        tick(); drive_op(32'd5, 32'd6, 1'b1, 1'b0, 5'd12);
        @(negedge clk); chk("fl_accept1", 64'(in_ready), 64'd1);
        tick(); flush = 1'b1; drive_op(32'd3, 32'd3, 1'b0, 1'b0, 5'd13);
        @(negedge clk); chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("fl_out_valid", 64'(out_valid), 64'd0);
        cnt = 0;
        repeat (6) begin
            tick();
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("fl_no_stale", 64'(cnt), 64'd0);
        run_op(32'd123, 32'd456, 1'b0, 1'b0, 5'd14, lat, p, r);
        chk("fl_new_latency", 64'(lat), 64'd3);
        chk("fl_new_prod", p, 64'd56088);

        // Reset while the op sits in S2.
        tick(); drive_op(32'h1234, 32'h5678, 1'b0, 1'b1, 5'd15);
        @(negedge clk); chk("rs_accept", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_out_result", 64'(out_result), 64'd0);
        chk("rs_out_prod", out_prod, 64'd0);
        chk("rs_in_ready", 64'(in_ready), 64'd1);
`ifdef MUL_CSA_PERF_CNT_EN
        chk("rs_perf_ops", 64'(perf_ops), 64'd0);
`endif
        cnt = 0;
        repeat (5) begin
            tick();
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rs_no_output", 64'(cnt), 64'd0);

        // Random traffic: operand-generated and raw partial-product vectors, stalls, flushes, resets.
        for (int cyc = 0; cyc < 500; cyc++) begin
            tick();
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 99) < 3);
            out_ready = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 99) < 70) begin
                if ($urandom_range(0, 1) == 0) begin
                    drive_op($urandom(), $urandom(), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), ID_W'(cyc));
                end else begin
                    for (int i = 0; i < 32; i++) in_pp[i] = $urandom();
                    in_sign   = $urandom();
                    in_signed = 1'($urandom_range(0, 1));
                    in_hi     = 1'($urandom_range(0, 1));
                    in_tag    = ID_W'(cyc);
                    in_valid  = 1'b1;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
